uart_transmitter: RTL and testbench

- Serial framing stage that sits directly upstream of the UART Receiver and drives its serialdata_in and tx_done inputs.
- Accepts one parallel word per request and serialises it as: 4-bit length field (MSB first), start bit 0, data bits (LSB first), optional parity bit, stop bit 1.
- The length field equals Data_length+parity_en+2, which is the value the Receiver uses to size its data phase.
- Contains its own baud-tick divider running from the single system clock.

---
 rtl/uart_transmitter.sv | 174 +++++++++++++++++
 tb/tb_uart_transmitter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter.sv
// ============================================================================
//  Module   : uart_transmitter
//  Purpose  : Length-prefixed UART framer: 4-bit length (MSB first), start,
//             data (LSB first), optional parity, stop; internal baud divider.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_transmitter #(
    parameter int DATA_LENGTH = 8,
    parameter int PARITY_EN   = 1,
    parameter int CLK_PER_BIT = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tx_start,
    input  logic                   parity_type,
    input  logic [DATA_LENGTH-1:0] parallel_datain,
    output logic                   serialdata_out,
    output logic                   tx_done
);

    localparam int c_CNT_W = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
    localparam int c_IDX_W = $clog2((DATA_LENGTH > 4) ? DATA_LENGTH : 4);

    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CLK_PER_BIT - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(DATA_LENGTH - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LEN  = c_IDX_W'(3);
    localparam logic [3:0]         c_LEN      = 4'(DATA_LENGTH + PARITY_EN + 2);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_LEN    = 3'd1;
    localparam logic [2:0] c_ST_START  = 3'd2;
    localparam logic [2:0] c_ST_DATA   = 3'd3;
    localparam logic [2:0] c_ST_PARITY = 3'd4;
    localparam logic [2:0] c_ST_STOP   = 3'd5;

    logic [2:0]             r_state,      w_state_nxt;
    logic [c_CNT_W-1:0]     r_baud_cnt,   w_baud_cnt_nxt;
    logic [c_IDX_W-1:0]     r_bit_idx,    w_bit_idx_nxt;
    logic [DATA_LENGTH-1:0] r_shift,      w_shift_nxt;
    logic [3:0]             r_len,        w_len_nxt;
    logic                   r_parity_bit, w_parity_bit_nxt;
    logic                   r_serial,     w_serial_nxt;
    logic                   r_tx_done,    w_tx_done_nxt;

    logic                   w_bit_end;
    logic [c_IDX_W-1:0]     w_idx_dec;
    logic [c_IDX_W-1:0]     w_idx_inc;
    logic [DATA_LENGTH-1:0] w_shift_dec;

    assign w_bit_end   = (r_baud_cnt == c_CNT_LAST);
    assign w_idx_dec   = r_bit_idx - c_IDX_W'(1);
    assign w_idx_inc   = r_bit_idx + c_IDX_W'(1);
    assign w_shift_dec = r_shift >> 1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= c_ST_IDLE;
            r_baud_cnt   <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_len        <= '0;
            r_parity_bit <= 1'b0;
            r_serial     <= 1'b1;
            r_tx_done    <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_baud_cnt   <= w_baud_cnt_nxt;
            r_bit_idx    <= w_bit_idx_nxt;
            r_shift      <= w_shift_nxt;
            r_len        <= w_len_nxt;
            r_parity_bit <= w_parity_bit_nxt;
            r_serial     <= w_serial_nxt;
            r_tx_done    <= w_tx_done_nxt;
        end
    end

    // Every next-state path also computes the next line level, so the serial
    // output is a plain flop and each bit starts exactly on a baud boundary.
    always_comb begin
        w_state_nxt      = r_state;
        w_baud_cnt_nxt   = w_bit_end ? '0 : (r_baud_cnt + c_CNT_W'(1));
        w_bit_idx_nxt    = r_bit_idx;
        w_shift_nxt      = r_shift;
        w_len_nxt        = r_len;
        w_parity_bit_nxt = r_parity_bit;
        w_serial_nxt     = r_serial;
        w_tx_done_nxt    = r_tx_done;

        case (r_state)
            c_ST_IDLE: begin
                w_baud_cnt_nxt = '0;
                w_serial_nxt   = 1'b1;
                w_tx_done_nxt  = 1'b1;
                if (tx_start) begin
                    w_state_nxt      = c_ST_LEN;
                    w_shift_nxt      = parallel_datain;
                    w_len_nxt        = c_LEN;
                    w_parity_bit_nxt = (^parallel_datain) ^ parity_type;
                    w_bit_idx_nxt    = c_IDX_LEN;
                    w_serial_nxt     = c_LEN[3];
                    w_tx_done_nxt    = 1'b0;
                end
            end

            c_ST_LEN: begin
                if (w_bit_end) begin
                    if (r_bit_idx == '0) begin
                        w_state_nxt  = c_ST_START;
                        w_serial_nxt = 1'b0;
                    end else begin
                        w_bit_idx_nxt = w_idx_dec;
                        w_serial_nxt  = r_len[w_idx_dec[1:0]];
                    end
                end
            end

            c_ST_START: begin
                if (w_bit_end) begin
                    w_state_nxt   = c_ST_DATA;
                    w_bit_idx_nxt = '0;
                    w_serial_nxt  = r_shift[0];
                end
            end

            c_ST_DATA: begin
                if (w_bit_end) begin
                    if (r_bit_idx == c_IDX_LAST) begin
                        if (PARITY_EN != 0) begin
                            w_state_nxt  = c_ST_PARITY;
                            w_serial_nxt = r_parity_bit;
                        end else begin
                            w_state_nxt  = c_ST_STOP;
                            w_serial_nxt = 1'b1;
                        end
                    end else begin
                        w_bit_idx_nxt = w_idx_inc;
                        w_shift_nxt   = w_shift_dec;
                        w_serial_nxt  = w_shift_dec[0];
                    end
                end
            end

            c_ST_PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt  = c_ST_STOP;
                    w_serial_nxt = 1'b1;
                end
            end

            c_ST_STOP: begin
                w_serial_nxt = 1'b1;
                if (w_bit_end) begin
                    w_state_nxt   = c_ST_IDLE;
                    w_tx_done_nxt = 1'b1;
                end
            end

            default: begin
                w_state_nxt    = c_ST_IDLE;
                w_baud_cnt_nxt = '0;
                w_serial_nxt   = 1'b1;
                w_tx_done_nxt  = 1'b1;
            end
        endcase
    end

    assign serialdata_out = r_serial;
    assign tx_done        = r_tx_done;

endmodule

`default_nettype wire

// File: tb/tb_uart_transmitter.sv
// ============================================================================
//  Module   : tb_uart_transmitter
//  Purpose  : Directed self-checking bench for uart_transmitter (parity and
//             no-parity builds).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_transmitter;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_start, ptype;
    logic [7:0] din;
    logic       sout, tdone;
    logic       tx_start_np, ptype_np;
    logic [7:0] din_np;
    logic       sout_np, tdone_np;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    uart_transmitter #(.DATA_LENGTH(8), .PARITY_EN(1), .CLK_PER_BIT(10)) dut (
        .clk(clk), .rst(rst), .tx_start(tx_start), .parity_type(ptype),
        .parallel_datain(din), .serialdata_out(sout), .tx_done(tdone)
    );

    uart_transmitter #(.DATA_LENGTH(8), .PARITY_EN(0), .CLK_PER_BIT(10)) dut_np (
        .clk(clk), .rst(rst), .tx_start(tx_start_np), .parity_type(ptype_np),
        .parallel_datain(din_np), .serialdata_out(sout_np), .tx_done(tdone_np)
    );

    // Leaves the caller on the first falling edge after the accepting edge.
    task automatic start_frame(input bit which, input logic [7:0] d, input logic p);
        @(negedge clk);
        if (which == 1'b0) begin
            tx_start = 1'b1; din = d; ptype = p;
        end else begin
            tx_start_np = 1'b1; din_np = d; ptype_np = p;
        end
        @(negedge clk);
        tx_start    = 1'b0;
        tx_start_np = 1'b0;
    endtask

    // Samples each bit mid-cell and counts busy cycles; mode 1 pokes tx_start
    // and new data at cycle 40, mode 2 swaps data to 8'h34 at cycle 50.
    task automatic capture(input bit which, input int mode,
                           output logic [14:0] bits, output int low);
        int c  = 0;
        int nb = which ? 14 : 15;
        bits = '0;
        low  = 0;
        while (((which ? tdone_np : tdone) == 1'b0) && c < 400) begin
            if ((c % 10) == 4 && (c / 10) < nb)
                bits[nb - 1 - (c / 10)] = which ? sout_np : sout;
            if (mode == 1 && c == 39) begin tx_start = 1'b1; din = 8'hFF; end
            if (mode == 1 && c == 40) tx_start = 1'b0;
            if (mode == 2 && c == 50) din = 8'h34;
            low++;
            c++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_total++; if (sout !== 1'b1) $display("FAIL reset_line: got %b want 1", sout); else n_pass++;
        n_total++; if (tdone !== 1'b1) $display("FAIL reset_done: got %b want 1", tdone); else n_pass++;
        n_total++; if (sout_np !== 1'b1) $display("FAIL reset_line_np: got %b want 1", sout_np); else n_pass++;
        n_total++; if (tdone_np !== 1'b1) $display("FAIL reset_done_np: got %b want 1", tdone_np); else n_pass++;
        rst = 1'b1;
    endtask

    task automatic test_parity_frames;
        logic [14:0] b;
        int          l;
        start_frame(0, 8'hA5, 1'b0); capture(0, 0, b, l);
        n_total++; if (b !== 15'b101101010010101) $display("FAIL a5_even_bits: got %b want %b", b, 15'b101101010010101); else n_pass++;
        n_total++; if (l !== 150) $display("FAIL a5_even_len: got %0d want 150", l); else n_pass++;
        start_frame(0, 8'hA5, 1'b1); capture(0, 0, b, l);
        n_total++; if (b !== 15'b101101010010111) $display("FAIL a5_odd_bits: got %b want %b", b, 15'b101101010010111); else n_pass++;
        n_total++; if (l !== 150) $display("FAIL a5_odd_len: got %0d want 150", l); else n_pass++;
        start_frame(0, 8'h01, 1'b0); capture(0, 0, b, l);
        n_total++; if (b !== 15'b101101000000011) $display("FAIL 01_even_bits: got %b want %b", b, 15'b101101000000011); else n_pass++;
        start_frame(0, 8'h01, 1'b1); capture(0, 0, b, l);
        n_total++; if (b !== 15'b101101000000001) $display("FAIL 01_odd_bits: got %b want %b", b, 15'b101101000000001); else n_pass++;
    endtask

    task automatic test_no_parity;
        logic [14:0] b;
        int          l;
        start_frame(1, 8'h3C, 1'b0); capture(1, 0, b, l);
        n_total++; if (b[13:0] !== 14'b10100001111001) $display("FAIL np_3c_bits: got %b want %b", b[13:0], 14'b10100001111001); else n_pass++;
        n_total++; if (l !== 140) $display("FAIL np_3c_len: got %0d want 140", l); else n_pass++;
    endtask

    task automatic test_ignore_midframe;
        logic [14:0] b;
        int          l;
        int          busy = 0;
        start_frame(0, 8'hA5, 1'b0); capture(0, 1, b, l);
        n_total++; if (b !== 15'b101101010010101) $display("FAIL midstart_bits: got %b want %b", b, 15'b101101010010101); else n_pass++;
        n_total++; if (l !== 150) $display("FAIL midstart_len: got %0d want 150", l); else n_pass++;
        repeat (30) begin
            @(negedge clk);
            if (tdone !== 1'b1 || sout !== 1'b1) busy++;
        end
        n_total++; if (busy !== 0) $display("FAIL midstart_no_second: got %0d busy cycles want 0", busy); else n_pass++;
    endtask

    task automatic test_reset_midframe;
        logic [14:0] b;
        int          l;
        start_frame(0, 8'h5A, 1'b0);
        repeat (70) @(negedge clk);
        n_total++; if (sout !== 1'b0) $display("FAIL midrst_pre_line: got %b want 0", sout); else n_pass++;
        #2 rst = 1'b0;
        #1;
        n_total++; if (sout !== 1'b1) $display("FAIL midrst_line: got %b want 1", sout); else n_pass++;
        n_total++; if (tdone !== 1'b1) $display("FAIL midrst_done: got %b want 1", tdone); else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        start_frame(0, 8'hA5, 1'b0); capture(0, 0, b, l);
        n_total++; if (b !== 15'b101101010010101) $display("FAIL postrst_bits: got %b want %b", b, 15'b101101010010101); else n_pass++;
        n_total++; if (l !== 150) $display("FAIL postrst_len: got %0d want 150", l); else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic [14:0] b1, b2;
        int          l1, l2;
        int          h = 1;
        logic        gap_line;
        @(negedge clk);
        tx_start = 1'b1; din = 8'h12; ptype = 1'b0;
        @(negedge clk);
        capture(0, 2, b1, l1);
        gap_line = sout;
        @(negedge clk);
        while (tdone === 1'b1 && h < 20) begin
            h++;
            @(negedge clk);
        end
        tx_start = 1'b0;
        capture(0, 0, b2, l2);
        n_total++; if (b1 !== 15'b101100100100001) $display("FAIL b2b_f1_bits: got %b want %b", b1, 15'b101100100100001); else n_pass++;
        n_total++; if (l1 !== 150) $display("FAIL b2b_f1_len: got %0d want 150", l1); else n_pass++;
        n_total++; if (h !== 1) $display("FAIL b2b_gap: got %0d idle cycles want 1", h); else n_pass++;
        n_total++; if (gap_line !== 1'b1) $display("FAIL b2b_gap_line: got %b want 1", gap_line); else n_pass++;
        n_total++; if (b2 !== 15'b101100010110011) $display("FAIL b2b_f2_bits: got %b want %b", b2, 15'b101100010110011); else n_pass++;
        n_total++; if (l2 !== 150) $display("FAIL b2b_f2_len: got %0d want 150", l2); else n_pass++;
    endtask

    initial begin
        rst = 1'b0;
        tx_start = 1'b0; ptype = 1'b0; din = 8'h00;
        tx_start_np = 1'b0; ptype_np = 1'b0; din_np = 8'h00;
        test_reset();
        test_parity_frames();
        test_no_parity();
        test_ignore_midframe();
        test_reset_midframe();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
